// File: rtl/vend_pkg.sv
// =============================================================================
// vend_pkg: shared types, status codes and coin rules for vending_machine_credit.
// Rev 1.0
// =============================================================================
`default_nettype none

package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CFG     = 2'd1,
        ST_COLLECT = 2'd2,
        ST_RESULT  = 2'd3
    } vend_state_e;

    typedef enum logic [1:0] {
        DISP_OK       = 2'd0,
        DISP_SOLD_OUT = 2'd1,
        DISP_CANCEL   = 2'd2,
        DISP_TIMEOUT  = 2'd3
    } disp_status_e;

    localparam int unsigned NUM_LEGAL_COINS = 5;
    localparam logic [NUM_LEGAL_COINS-1:0][7:0] LEGAL_COINS =
        {8'd100, 8'd50, 8'd20, 8'd10, 8'd5};

    function automatic logic is_legal_coin(input logic [31:0] value);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_LEGAL_COINS; i++) begin
            if (value == 32'(LEGAL_COINS[i])) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Table entries are packed {dispensed, available, price}, price at bit 0.
    localparam int unsigned ENTRY_PRICE_LSB = 0;

    function automatic int unsigned entry_avail_lsb(input int unsigned price_w);
        return price_w;
    endfunction

    function automatic int unsigned entry_disp_lsb(input int unsigned price_w,
                                                   input int unsigned cnt_w);
        return price_w + cnt_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vend_idle_timer.sv
// =============================================================================
// vend_idle_timer: counts run cycles since the last restart, flags expiry.
// Rev 1.0
// =============================================================================
`default_nettype none

module vend_idle_timer #(
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic run,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (restart) begin
            count_d = '0;
        end else if (run && count_q != LAST_CNT) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Count 0 is the first cycle after restart, so the last count closes TIMEOUT_CYC cycles.
    assign expired = run && !restart && (count_q == LAST_CNT);

endmodule

`default_nettype wire

// File: rtl/vending_machine_credit.sv
// =============================================================================
// vending_machine_credit: multi-coin credit vending controller with item table.
// Optional idle timeout enabled by defining VEND_TIMEOUT_EN.   Rev 1.0
// =============================================================================
`default_nettype none

module vending_machine_credit
    import vend_pkg::*;
#(
    parameter int unsigned NUM_ITEMS   = 64,
    parameter int unsigned PRICE_W     = 16,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned COIN_W      = 7,
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    localparam int unsigned IW         = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_mode,
    input  logic                 cfg_we,
    input  logic [IW-1:0]        cfg_addr,
    input  logic [31:0]          cfg_wdata,
    output logic [31:0]          cfg_rdata,
    input  logic                 coin_valid,
    input  logic [COIN_W-1:0]    coin_value,
    output logic                 coin_reject,
    input  logic                 sel_valid,
    input  logic [IW-1:0]        sel_item,
    input  logic                 cancel,
    output logic                 disp_valid,
    input  logic                 disp_ready,
    output logic [IW-1:0]        disp_item,
    output logic [1:0]           disp_status,
    output logic [PRICE_W:0]     disp_change,
    output logic                 busy
);

    localparam int unsigned ENTRY_W   = PRICE_W + 2 * CNT_W;
    localparam int unsigned AVAIL_LSB = entry_avail_lsb(PRICE_W);
    localparam int unsigned DISP_LSB  = entry_disp_lsb(PRICE_W, CNT_W);
    localparam int unsigned CR_W      = PRICE_W + 1;
    localparam logic [IW:0] ITEM_LIMIT = (IW + 1)'(NUM_ITEMS);

    vend_state_e        state_q, state_d;
    logic [ENTRY_W-1:0] table_q [NUM_ITEMS];
    logic [ENTRY_W-1:0] table_d [NUM_ITEMS];
    logic [IW-1:0]      item_q, item_d;
    logic [CR_W-1:0]    credit_q, credit_d;
    logic [31:0]        cfg_rdata_q, cfg_rdata_d;
    logic               coin_reject_q, coin_reject_d;
    logic               disp_valid_q, disp_valid_d;
    logic [IW-1:0]      disp_item_q, disp_item_d;
    disp_status_e       disp_status_q, disp_status_d;
    logic [CR_W-1:0]    disp_change_q, disp_change_d;

    logic               sel_in_range, cfg_in_range, sel_ok;
    logic [ENTRY_W-1:0] sel_entry, cur_entry;
    logic [PRICE_W-1:0] cur_price;
    logic [CNT_W-1:0]   cur_avail, cur_disp;
    logic               coin_accept, sale, timer_expired;
    logic [CR_W-1:0]    new_credit;

    assign sel_in_range = {1'b0, sel_item} < ITEM_LIMIT;
    assign cfg_in_range = {1'b0, cfg_addr} < ITEM_LIMIT;
    assign sel_entry    = sel_in_range ? table_q[sel_item] : '0;
    assign sel_ok       = sel_in_range && (sel_entry[AVAIL_LSB +: CNT_W] != '0);

    assign cur_entry = table_q[item_q];
    assign cur_price = cur_entry[ENTRY_PRICE_LSB +: PRICE_W];
    assign cur_avail = cur_entry[AVAIL_LSB +: CNT_W];
    assign cur_disp  = cur_entry[DISP_LSB +: CNT_W];

    // Only COLLECT credits coins; everything else is returned through coin_reject.
    assign coin_accept = (state_q == ST_COLLECT) && coin_valid && is_legal_coin(32'(coin_value));
    assign new_credit  = credit_q + (coin_accept ? CR_W'(coin_value) : '0);
    assign sale        = coin_accept && (new_credit >= {1'b0, cur_price});

`ifdef VEND_TIMEOUT_EN
    logic timer_restart;
    assign timer_restart = ((state_q == ST_IDLE) && !cfg_mode && sel_valid && sel_ok) || coin_accept;

    vend_idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (timer_restart),
        .run     (state_q == ST_COLLECT),
        .expired (timer_expired)
    );
`else
    // TIMEOUT_CYC only matters when the timer is built.
    assign timer_expired = 1'b0 & TIMEOUT_CYC[0];
`endif

    always_comb begin
        state_d       = state_q;
        table_d       = table_q;
        item_d        = item_q;
        credit_d      = credit_q;
        cfg_rdata_d   = cfg_rdata_q;
        coin_reject_d = coin_valid && !coin_accept;
        disp_valid_d  = disp_valid_q;
        disp_item_d   = disp_item_q;
        disp_status_d = disp_status_q;
        disp_change_d = disp_change_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_mode) begin
                    state_d = ST_CFG;
                end else if (sel_valid) begin
                    if (sel_ok) begin
                        item_d   = sel_item;
                        credit_d = '0;
                        state_d  = ST_COLLECT;
                    end else begin
                        state_d       = ST_RESULT;
                        disp_valid_d  = 1'b1;
                        disp_item_d   = sel_item;
                        disp_status_d = DISP_SOLD_OUT;
                        disp_change_d = '0;
                    end
                end
            end
            ST_CFG: begin
                if (cfg_we && cfg_in_range) begin
                    table_d[cfg_addr] = cfg_wdata[ENTRY_W-1:0];
                end
                cfg_rdata_d = cfg_in_range ? 32'(table_q[cfg_addr]) : '0;
                if (!cfg_mode) begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                credit_d = new_credit;
                if (sale) begin
                    table_d[item_q][AVAIL_LSB +: CNT_W] = cur_avail - 1'b1;
                    table_d[item_q][DISP_LSB +: CNT_W]  = (&cur_disp) ? cur_disp : cur_disp + 1'b1;
                    state_d       = ST_RESULT;
                    disp_valid_d  = 1'b1;
                    disp_item_d   = item_q;
                    disp_status_d = DISP_OK;
                    disp_change_d = new_credit - {1'b0, cur_price};
                end else if (cancel) begin
                    state_d       = ST_RESULT;
                    disp_valid_d  = 1'b1;
                    disp_item_d   = item_q;
                    disp_status_d = DISP_CANCEL;
                    disp_change_d = new_credit;
                end else if (timer_expired) begin
                    state_d       = ST_RESULT;
                    disp_valid_d  = 1'b1;
                    disp_item_d   = item_q;
                    disp_status_d = DISP_TIMEOUT;
                    disp_change_d = credit_q;
                end
            end
            ST_RESULT: begin
                if (disp_ready) begin
                    disp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                table_q[i] <= '0;
            end
            item_q        <= '0;
            credit_q      <= '0;
            cfg_rdata_q   <= '0;
            coin_reject_q <= 1'b0;
            disp_valid_q  <= 1'b0;
            disp_item_q   <= '0;
            disp_status_q <= DISP_OK;
            disp_change_q <= '0;
        end else begin
            state_q       <= state_d;
            table_q       <= table_d;
            item_q        <= item_d;
            credit_q      <= credit_d;
            cfg_rdata_q   <= cfg_rdata_d;
            coin_reject_q <= coin_reject_d;
            disp_valid_q  <= disp_valid_d;
            disp_item_q   <= disp_item_d;
            disp_status_q <= disp_status_d;
            disp_change_q <= disp_change_d;
        end
    end

    assign cfg_rdata   = cfg_rdata_q;
    assign coin_reject = coin_reject_q;
    assign disp_valid  = disp_valid_q;
    assign disp_item   = disp_item_q;
    assign disp_status = disp_status_q;
    assign disp_change = disp_change_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_vending_machine_credit.sv
// =============================================================================
// tb_vending_machine_credit: directed and randomized purchases against a table model.
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_vending_machine_credit;

    localparam int NI  = 10;
    localparam int PW  = 16;
    localparam int CW  = 8;
    localparam int COW = 7;
    localparam int TO  = 16;
    localparam int IW  = $clog2(NI);

    localparam int ST_OK = 0, ST_SOLD = 1, ST_CANCEL = 2, ST_TIMEOUT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_mode = 1'b0, cfg_we = 1'b0;
    logic [IW-1:0] cfg_addr = '0;
    logic [31:0]   cfg_wdata = '0;
    logic [31:0]   cfg_rdata;
    logic          coin_valid = 1'b0;
    logic [COW-1:0] coin_value = '0;
    logic          coin_reject;
    logic          sel_valid = 1'b0;
    logic [IW-1:0] sel_item = '0;
    logic          cancel = 1'b0;
    logic          disp_valid;
    logic          disp_ready = 1'b0;
    logic [IW-1:0] disp_item;
    logic [1:0]    disp_status;
    logic [PW:0]   disp_change;
    logic          busy;

    int tests = 0;
    int fails = 0;

    int m_price [NI];
    int m_avail [NI];
    int m_disp  [NI];

    int legal_list   [5] = '{5, 10, 20, 50, 100};
    int illegal_list [6] = '{1, 3, 7, 25, 99, 127};

    vending_machine_credit #(
        .NUM_ITEMS   (NI),
        .PRICE_W     (PW),
        .CNT_W       (CW),
        .COIN_W      (COW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_mode    (cfg_mode),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_rdata   (cfg_rdata),
        .coin_valid  (coin_valid),
        .coin_value  (coin_value),
        .coin_reject (coin_reject),
        .sel_valid   (sel_valid),
        .sel_item    (sel_item),
        .cancel      (cancel),
        .disp_valid  (disp_valid),
        .disp_ready  (disp_ready),
        .disp_item   (disp_item),
        .disp_status (disp_status),
        .disp_change (disp_change),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input int v);
        foreach (legal_list[i]) if (legal_list[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_entry(input int i);
        return 32'((m_disp[i] << 24) | (m_avail[i] << 16) | m_price[i]);
    endfunction

    task automatic cfg_read_check(input int first, input int last);
        cfg_mode = 1'b1;
        step();
        for (int i = first; i <= last; i++) begin
            cfg_addr = IW'(i);
            step();
            check($sformatf("cfg_read_%0d", i), cfg_rdata, model_entry(i));
        end
        cfg_mode = 1'b0;
        step();
        check("cfg_exit_busy", busy, 0);
    endtask

    task automatic finish_result(input int item, input int status, input int change, input int ready_delay);
        check("res_valid", disp_valid, 1);
        check("res_item", disp_item, item);
        check("res_status", disp_status, status);
        check("res_change", disp_change, change);
        if (ready_delay == 0) begin
            step();
            check("res_onecycle_valid", disp_valid, 0);
        end else begin
            for (int d = 0; d < ready_delay; d++) begin
                sel_valid  = 1'b1;
                sel_item   = IW'(3);
                coin_valid = 1'b1;
                coin_value = COW'(10);
                step();
                check("hold_valid", disp_valid, 1);
                check("hold_item", disp_item, item);
                check("hold_status", disp_status, status);
                check("hold_change", disp_change, change);
                check("hold_reject", coin_reject, 1);
            end
            sel_valid  = 1'b0;
            coin_valid = 1'b0;
            disp_ready = 1'b1;
            step();
            check("ack_valid", disp_valid, 0);
            check("ack_reject", coin_reject, 0);
        end
        check("ack_idle", busy, 0);
        disp_ready = 1'b0;
    endtask

    // Plays one purchase; coin value 0 means an empty cycle. Returns done=0 if still collecting.
    task automatic purchase(input int item, input int coins[$], input bit cancel_last,
                            input int ready_delay, output bit done);
        int credit = 0;
        int st = 0;
        int chg = 0;
        done = 1'b0;
        disp_ready = (ready_delay == 0);
        sel_valid = 1'b1;
        sel_item  = IW'(item);
        step();
        sel_valid = 1'b0;
        if (item >= NI || m_avail[item] == 0) begin
            done = 1'b1;
            st   = ST_SOLD;
            chg  = 0;
        end else begin
            check("sel_busy", busy, 1);
            check("sel_novalid", disp_valid, 0);
            for (int k = 0; k < coins.size() && !done; k++) begin
                bit leg = is_legal(coins[k]);
                bit can = cancel_last && (k == coins.size() - 1);
                coin_valid = (coins[k] != 0);
                coin_value = COW'(coins[k]);
                cancel     = can;
                step();
                coin_valid = 1'b0;
                cancel     = 1'b0;
                check("coin_reject", coin_reject, (coins[k] != 0) && !leg);
                if (leg) credit += coins[k];
                if (leg && credit >= m_price[item]) begin
                    done = 1'b1;
                    st   = ST_OK;
                    chg  = credit - m_price[item];
                    m_avail[item]--;
                    if (m_disp[item] < 255) m_disp[item]++;
                end else if (can) begin
                    done = 1'b1;
                    st   = ST_CANCEL;
                    chg  = credit;
                end else begin
                    check("collect_wait", disp_valid, 0);
                end
            end
        end
        if (done) finish_result(item, st, chg, ready_delay);
    endtask

    initial begin
        bit done;
        int q[$];

        // Reset state, sampled while reset is still asserted.
        repeat (3) step();
        check("rst_disp_valid", disp_valid, 0);
        check("rst_coin_reject", coin_reject, 0);
        check("rst_busy", busy, 0);
        check("rst_cfg_rdata", cfg_rdata, 0);
        check("rst_disp_change", disp_change, 0);
        check("rst_disp_item", disp_item, 0);
        check("rst_disp_status", disp_status, 0);
        rst = 1'b0;
        step();

        // A coin in IDLE is bounced.
        coin_valid = 1'b1;
        coin_value = COW'(20);
        step();
        coin_valid = 1'b0;
        check("idle_coin_reject", coin_reject, 1);
        check("idle_busy", busy, 0);
        step();
        check("idle_reject_pulse", coin_reject, 0);

        for (int i = 0; i < NI; i++) begin
            m_price[i] = 5 * $urandom_range(1, 30);
            m_avail[i] = $urandom_range(0, 3);
            m_disp[i]  = $urandom_range(0, 255);
        end
        m_price[3] = 15; m_avail[3] = 2; m_disp[3] = 0;
        m_price[4] = 35; m_avail[4] = 1; m_disp[4] = 0;
        m_price[5] = 50; m_avail[5] = 2; m_disp[5] = 0;
        m_price[6] = 20; m_avail[6] = 0; m_disp[6] = 4;
        m_price[7] = 0;  m_avail[7] = 1; m_disp[7] = 0;
        m_price[8] = 10; m_avail[8] = 1; m_disp[8] = 255;

        cfg_mode = 1'b1;
        step();
        check("cfg_busy", busy, 1);
        cfg_we = 1'b1;
        for (int i = 0; i < NI; i++) begin
            cfg_addr  = IW'(i);
            cfg_wdata = model_entry(i);
            step();
        end
        cfg_addr  = IW'(12);
        cfg_wdata = 32'hFFFF_FFFF;
        step();
        cfg_we = 1'b0;
        step();
        check("cfg_read_oob", cfg_rdata, 0);
        cfg_mode = 1'b0;
        step();
        cfg_read_check(0, NI - 1);

        purchase(3, '{20}, 1'b0, 2, done);
        cfg_read_check(3, 3);

        purchase(4, '{10, 7, 5, 20}, 1'b0, 0, done);
        purchase(6, '{5}, 1'b0, 1, done);
        purchase(12, '{5}, 1'b0, 0, done);
        purchase(5, '{20, 10}, 1'b1, 1, done);
        purchase(3, '{5, 0, 10}, 1'b0, 5, done);
        purchase(3, '{5}, 1'b0, 1, done);
        purchase(7, '{0, 3, 50}, 1'b0, 1, done);
        purchase(8, '{10}, 1'b0, 0, done);
        cfg_read_check(3, 8);

        // Idle-timeout behaviour, or its absence.
        purchase(5, '{5}, 1'b0, 1, done);
        check("to_collecting", done, 0);
`ifdef VEND_TIMEOUT_EN
        for (int c = 0; c < TO - 1; c++) step();
        check("to_not_yet", disp_valid, 0);
        step();
        finish_result(5, ST_TIMEOUT, 5, 1);
`else
        for (int c = 0; c < 1000; c++) step();
        check("no_to_busy", busy, 1);
        check("no_to_valid", disp_valid, 0);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        finish_result(5, ST_CANCEL, 5, 1);
`endif

        for (int t = 0; t < 40; t++) begin
            int it = $urandom_range(0, 11);
            int n  = $urandom_range(1, 8);
            q.delete();
            for (int k = 0; k < n; k++) begin
                int r = $urandom_range(0, 9);
                if (r < 2) q.push_back(0);
                else if (r == 2) q.push_back(illegal_list[$urandom_range(0, 5)]);
                else q.push_back(legal_list[$urandom_range(0, 4)]);
            end
            purchase(it, q, 1'b1, $urandom_range(0, 3), done);
        end

        cfg_read_check(0, NI - 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vending_machine_credit.md
# vending_machine_credit

Parametrised successor of the team's single-coin vending controller: a single-clock block that holds a per-item table of price, available count and dispensed count, accepts multiple coins per purchase, and accumulates credit until the price is met. It supports customer cancel with refund, rejects illegal coins immediately, and presents each result through a valid/ready dispense handshake. It sits between the coin/keypad front end, already synchronised into `clk`, and the dispense actuator.

## Interface
- `NUM_ITEMS`, default 64: number of item slots; the item index width is `$clog2(NUM_ITEMS)`.
- `PRICE_W`, default 16: price field width.
- `CNT_W`, default 8: width of the available and dispensed counters. `PRICE_W + 2*CNT_W` must be ≤ 32.
- `COIN_W`, default 7: coin value width.
- `TIMEOUT_CYC`, default 1_000_000: idle cycles in COLLECT before an automatic refund.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `cfg_mode`  in  1: configuration request, sampled only in IDLE.
- `cfg_we`  in  1: table write strobe, used in CFG.
- `cfg_addr`  in  IW: item index.
- `cfg_wdata`  in  32: `{dispensed, available, price}` packed LSB-first.
- `cfg_rdata`  out  32: registered table read.
- `coin_valid`  in  1: one-cycle coin strobe.
- `coin_value`  in  COIN_W: coin value.
- `coin_reject`  out  1: one-cycle pulse when a coin is returned unaccepted.
- `sel_valid`  in  1: item select strobe.
- `sel_item`  in  IW: selected item.
- `cancel`  in  1: customer cancel strobe.
- `disp_valid`  out  1: result valid.
- `disp_ready`  in  1: actuator accepts the result.
- `disp_item`  out  IW: dispensed item.
- `disp_status`  out  2: result code (OK / SOLD_OUT / CANCEL / TIMEOUT).
- `disp_change`  out  PRICE_W+1: change returned.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- **States:** IDLE, CFG, COLLECT, RESULT.
- **IDLE:**
  - `cfg_mode` = 1 → CFG. This has priority over `sel_valid`.
  - On `sel_valid`: if `sel_item` ≥ `NUM_ITEMS` or its available count is 0 → RESULT with SOLD_OUT, change 0, and `disp_item` = `sel_item`.
  - Otherwise, latch the item, clear credit → COLLECT.
- **CFG:**
  - `cfg_we` writes entry `cfg_addr`.
  - `cfg_rdata` is updated every cycle with entry `cfg_addr` (1-cycle latency).
  - `cfg_mode` = 0 → IDLE.
  - `cfg_addr` ≥ `NUM_ITEMS`: writes are ignored and reads return 0.
- **COLLECT:**
  - Legal coins are 5, 10, 20, 50 and 100. `new_credit` = credit + (legal `coin_valid` ? `coin_value` : 0).
  - An illegal coin pulses `coin_reject` the next cycle; credit is unchanged.
  - If `new_credit` ≥ price → RESULT with OK, change = `new_credit` − price. The entry updates on the same edge: available −1; dispensed +1, saturating at all-ones.
  - Else if `cancel` → RESULT with CANCEL, change = `new_credit`.
  - Else, on timer expiry → RESULT with TIMEOUT, change = credit.
  - Priority: sale > cancel > timeout. A coin arriving in the same cycle as `cancel` is refunded.
  - `sel_valid` is ignored.
  - Credit never exceeds price + 99 before resolving, so `PRICE_W+1` bits cannot overflow.
  - A price of 0 dispenses on the first legal coin, with change equal to that coin.
- **RESULT:** hold `disp_valid` and all `disp_*` outputs stable until `disp_ready`, then → IDLE.
- **Coins outside COLLECT:** any coin in IDLE, CFG or RESULT pulses `coin_reject` and is not credited.

## Timing
- **Reset values:** all outputs are 0; the table is all zero; credit is 0; state is IDLE. Reset during COLLECT discards credit without a refund.
- **Event to result:** `disp_valid` rises one cycle after the deciding event (`sel_valid`, coin, `cancel` or expiry).
- **Handshake:** transfer occurs on the edge where `disp_valid` and `disp_ready` are both high. `disp_valid` is 0 on the following cycle, and a new `sel_valid` is accepted from that cycle.
- **Ready already high:** if `disp_ready` is high when `disp_valid` rises, `disp_valid` lasts exactly 1 cycle.
- **Reject pulse:** `coin_reject` lasts 1 cycle, one cycle after `coin_valid`.
- **Table update vs. config:** the table update on OK is visible to a CFG read issued at any later time.

## Configuration
- **Macro:** `VEND_TIMEOUT_EN`.
- **Defined:** an idle timer counts cycles in COLLECT. It restarts on entry to COLLECT and on every legal coin, and expires after `TIMEOUT_CYC` cycles without a legal coin, yielding TIMEOUT.
- **Undefined:** no timer logic is built. COLLECT waits indefinitely, and TIMEOUT is never produced.

## Structure
- **Package `vend_pkg`:**
  - State enum.
  - `disp_status` codes: OK = 0, SOLD_OUT = 1, CANCEL = 2, TIMEOUT = 3.
  - Legal-coin constant list and an `is_legal_coin` function.
  - Entry field offset localparams.
- **Sub-module `vend_idle_timer`:** inputs `clk`, `rst`, `restart`, `run`; output `expired`. Instantiated only under `VEND_TIMEOUT_EN`.

## Test plan
- **Config then single-coin sale:** write item 3 = price 15, avail 2, disp 0; select 3; insert 20 → OK, item 3, change 5; CFG read of item 3 returns avail 1, disp 1.
- **Accumulation:** price 35 with coins 10, 5, 20 → exactly one OK after the 20, change 0. An illegal coin of 7 mid-sequence gives `coin_reject` and no credit.
- **Sold out:** select an item with avail 0 → SOLD_OUT, change 0. `sel_item` ≥ `NUM_ITEMS` gives the same result.
- **Cancel:** price 50; insert 20; then `cancel` together with a 10 coin → CANCEL, change 30.
- **Handshake hold:** hold `disp_ready` low for 5 cycles → outputs stay stable, a new `sel_valid` is ignored, and coins are rejected; raise ready → IDLE next cycle.
- **Timeout (macro defined, `TIMEOUT_CYC` = 16):** insert 5 and wait 16 cycles → TIMEOUT, change 5. With the macro undefined → still in COLLECT after 1000 cycles.
